// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared states, nibble width and clog2 helper for the nibble-serial adder
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/fa_4bits.sv
// rtl/fa_4bits.sv - 4-bit ripple-carry adder slice shared by every nibble pass
module fa_4bits (
   input  logic [3:0] i0,
   input  logic [3:0] i1,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] c;

   always_comb begin
      sum  = '0;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < 4; i++) begin
         sum[i]   = i0[i] ^ i1[i] ^ c[i];
         c[i + 1] = (i0[i] & i1[i]) | (c[i] & (i0[i] ^ i1[i]));
      end
      cout = c[4];
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit add/subtract done one nibble per cycle through one fa_4bits
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NIB   = WIDTH / NIBBLE_W;
   localparam int CNT_W = (clog2(NIB) < 1) ? 1 : clog2(NIB);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic [3:0]         nib_sum;
   logic               nib_cout;
   logic               last_nib;

   fa_4bits u_fa (
      .i0   (a_sh_q[3:0]),
      .i1   (b_sh_q[3:0]),
      .cin  (carry_q),
      .sum  (nib_sum),
      .cout (nib_cout)
   );

   assign last_nib = (cnt_q == CNT_W'(NIB - 1));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               // Subtract is a + ~b + 1: invert B up front and seed the carry with 1.
               a_sh_d  = a;
               b_sh_d  = op_sub ? ~b : b;
               carry_d = op_sub ? 1'b1 : cin;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            sum_sh_d = {nib_sum, sum_sh_q[WIDTH-1:NIBBLE_W]};
            a_sh_d   = a_sh_q >> NIBBLE_W;
            b_sh_d   = b_sh_q >> NIBBLE_W;
            carry_d  = nib_cout;
            if (last_nib) begin
               // The top nibble is in the slice now, so bit 3 of each operand is the sign bit.
               cnt_d   = '0;
               sum_d   = sum_sh_d;
               cout_d  = nib_cout;
               ovf_d   = (a_sh_q[3] == b_sh_q[3]) && (nib_sum[3] != a_sh_q[3]);
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - scoreboard bench for nibble_serial_adder against an arithmetic reference model
module tb_nibble_serial_adder;

   localparam int W   = 16;
   localparam int NIB = W / 4;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           acc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         op_sub = 1'b0;
   logic         cin = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, cout, ovf;
   logic [W-1:0] sum;

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   exp_t sb_q[$];
   exp_t last_exp;

   nibble_serial_adder #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op_sub (op_sub),
      .cin    (cin),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .sum    (sum),
      .cout   (cout),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference model: plain integer arithmetic on the whole operands.
   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic msub, input logic mcin, input int acc);
      exp_t e;
      int   ua, ub, sa, sb, u, r;
      ua = int'(ma);
      ub = int'(mb);
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      if (!msub) begin
         u      = ua + ub + int'(mcin);
         r      = sa + sb + int'(mcin);
         e.cout = (u > 65535);
      end else begin
         u      = ua - ub;
         r      = sa - sb;
         e.cout = (ua >= ub);
      end
      e.sum = u[W-1:0];
      e.ovf = (r > 32767) || (r < -32768);
      e.acc = acc;
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", 32'(done), 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("sum", 32'(sum), 32'(e.sum));
               check("cout", 32'(cout), 32'(e.cout));
               check("ovf", 32'(ovf), 32'(e.ovf));
               check("latency_edges", 32'(cyc + 1 - e.acc), 32'(NIB + 1));
               check("busy_in_done", 32'(busy), 32'd1);
               last_exp = e;
            end
         end else begin
            check("sum_hold", 32'(sum), 32'(last_exp.sum));
            check("flags_hold", {30'd0, cout, ovf}, {30'd0, last_exp.cout, last_exp.ovf});
         end
      end
   end

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (busy) check("idle_timeout", 32'(busy), 32'd0);
   endtask

   // Returns at the negedge following the accepting edge, with inputs scrambled.
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub, input logic icin);
      @(negedge clk);
      wait_idle();
      a      = ia;
      b      = ib;
      op_sub = isub;
      cin    = icin;
      start  = 1'b1;
      sb_q.push_back(model(ia, ib, isub, icin, cyc + 1));
      @(negedge clk);
      start  = 1'b0;
      a      = W'($urandom);
      b      = W'($urandom);
      op_sub = 1'($urandom);
      cin    = 1'($urandom);
      check("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sb_q.size() != 0 || busy) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      last_exp = '{sum: '0, cout: 1'b0, ovf: 1'b0, acc: 0};
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_sum", 32'(sum), 32'd0);
      check("reset_flags", {30'd0, cout, ovf}, 32'd0);

      issue(16'h1234, 16'h4321, 1'b0, 1'b0);
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      issue(16'h0005, 16'h0007, 1'b1, 1'b0);
      issue(16'h8000, 16'h0001, 1'b1, 1'b1);
      issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
      drain();

      // A start pulse during RUN must be ignored.
      issue(16'hA5A5, 16'h1111, 1'b0, 1'b0);
      @(negedge clk);
      a     = 16'h0F0F;
      b     = 16'h0101;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (8) @(negedge clk);

      // Start held high: acceptances every NIB+2 edges.
      @(negedge clk);
      wait_idle();
      a      = 16'h2222;
      b      = 16'h3333;
      op_sub = 1'b0;
      cin    = 1'b1;
      start  = 1'b1;
      for (int k = 0; k < 3; k++)
         sb_q.push_back(model(16'h2222, 16'h3333, 1'b0, 1'b1, cyc + 1 + k * (NIB + 2)));
      repeat (2 * (NIB + 2) + 1) @(negedge clk);
      start = 1'b0;
      drain();

      // Asynchronous reset in the third RUN cycle aborts without a done pulse.
      issue(16'h1357, 16'h2468, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      sb_q.delete();
      last_exp = '{sum: '0, cout: 1'b0, ovf: 1'b0, acc: 0};
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_sum", 32'(sum), 32'd0);
      check("abort_flags", {30'd0, cout, ovf}, 32'd0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      repeat (NIB + 3) @(negedge clk);
      issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
      drain();

      for (int i = 0; i < 40; i++)
         issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      drain();
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
